// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the alu_ctrl sequencer and its alu datapath.
package alu_ctrl_pkg;

  localparam int WIDTH     = 8;
  localparam int REG_COUNT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_PASS = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'hE;
  localparam logic [3:0] OP_MUL  = 4'hF;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU: carry is carry-out for ADD, borrow for SUB,
// and the shifted-out bit for shifts; unassigned opcodes yield zero.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_carry
);
  import alu_ctrl_pkg::*;

  logic [WIDTH:0] w_wide;

  always_comb begin
    w_wide = '0;
    case (i_op)
      OP_ADD:  w_wide = {1'b0, i_a} + {1'b0, i_b};
      OP_SUB:  w_wide = {1'b0, i_a} - {1'b0, i_b};
      OP_AND:  w_wide = {1'b0, i_a & i_b};
      OP_OR:   w_wide = {1'b0, i_a | i_b};
      OP_XOR:  w_wide = {1'b0, i_a ^ i_b};
      OP_SHL:  w_wide = {i_a, 1'b0};
      OP_SHR:  w_wide = {i_a[0], 1'b0, i_a[WIDTH-1:1]};
      OP_PASS: w_wide = {1'b0, i_a};
      default: w_wide = '0;
    endcase
  end

  assign o_result = w_wide[WIDTH-1:0];
  assign o_carry  = w_wide[WIDTH];
  assign o_zero   = (w_wide[WIDTH-1:0] == '0);

endmodule

// File: rtl/alu_ctrl.sv
// Command sequencer around the alu: register file, single-cycle ops, LDI,
// and an 8-iteration shift-add multiply that reuses the ALU's ADD.
module alu_ctrl #(
  parameter int WIDTH     = 8,
  parameter int REG_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [1:0]       cmd_rd,
  input  logic [1:0]       cmd_rs,
  input  logic [1:0]       cmd_rt,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             done,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             busy
);
  import alu_ctrl_pkg::*;

  state_t r_state, w_state_nxt;

  logic [WIDTH-1:0] r_regs [REG_COUNT];
  logic [3:0]       r_op;
  logic [1:0]       r_rd;
  logic [WIDTH-1:0] r_imm, r_opa, r_opb;
  logic [WIDTH-1:0] r_acc, r_mcand, r_mplier;
  logic [2:0]       r_cnt;
  logic             r_ovf, r_lost;

  logic             w_accept;
  logic [WIDTH-1:0] w_alu_a, w_alu_b, w_alu_result, w_acc_nxt;
  logic [3:0]       w_alu_op;
  logic             w_alu_zero, w_alu_carry, w_ovf_nxt;

  assign cmd_ready = (r_state == IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;
  assign done      = (r_state == DONE);
  assign busy      = (r_state != IDLE);

  // In MUL the ALU is borrowed as the accumulator adder.
  assign w_alu_a  = (r_state == MUL) ? r_acc   : r_opa;
  assign w_alu_b  = (r_state == MUL) ? r_mcand : r_opb;
  assign w_alu_op = (r_state == MUL) ? OP_ADD  : r_op;

  alu #(.WIDTH(WIDTH)) u_alu (
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .i_op     (w_alu_op),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero),
    .o_carry  (w_alu_carry)
  );

  // Bits already shifted out of mcand make any later partial product overflow.
  assign w_acc_nxt = r_mplier[0] ? w_alu_result : r_acc;
  assign w_ovf_nxt = r_ovf | (r_mplier[0] & (w_alu_carry | r_lost));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = (cmd_op == OP_MUL) ? MUL : EXEC;
      EXEC: w_state_nxt = DONE;
      MUL:  if (r_cnt == 3'd7) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
      r_op       <= '0;
      r_rd       <= '0;
      r_imm      <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_lost     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op     <= cmd_op;
            r_rd     <= cmd_rd;
            r_imm    <= cmd_imm;
            r_opa    <= r_regs[cmd_rs];
            r_opb    <= r_regs[cmd_rt];
            r_acc    <= '0;
            r_mcand  <= r_regs[cmd_rs];
            r_mplier <= r_regs[cmd_rt];
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_lost   <= 1'b0;
          end
        end
        EXEC: begin
          if (r_op == OP_LDI) begin
            r_regs[r_rd] <= r_imm;
            rsp_result   <= r_imm;
            rsp_zero     <= (r_imm == '0);
            rsp_carry    <= 1'b0;
          end else begin
            r_regs[r_rd] <= w_alu_result;
            rsp_result   <= w_alu_result;
            rsp_zero     <= w_alu_zero;
            rsp_carry    <= w_alu_carry;
          end
        end
        MUL: begin
          r_acc    <= w_acc_nxt;
          r_ovf    <= w_ovf_nxt;
          r_lost   <= r_lost | r_mcand[WIDTH-1];
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_regs[r_rd] <= w_acc_nxt;
            rsp_result   <= w_acc_nxt;
            rsp_zero     <= (w_acc_nxt == '0);
            rsp_carry    <= w_ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed vector table, hand sequences for
// streaming and mid-multiply reset, and random commands against a model.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs, cmd_rt;
  logic [7:0] cmd_imm, rsp_result;
  logic       done, rsp_zero, rsp_carry, busy;

  int checks = 0;
  int errors = 0;
  int mregs[4];

  always #5 clk = ~clk;

  alu_ctrl #(.WIDTH(8), .REG_COUNT(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_imm(cmd_imm), .done(done), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .busy(busy)
  );

  typedef struct {
    logic [3:0] op;
    logic [1:0] rd, rs, rt;
    logic [7:0] imm;
    logic [7:0] res;
    logic       z, c;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int op, input int rd, input int rs, input int rt,
                              input int imm, input int res, input int z, input int c);
    vec_t v;
    v.op = op[3:0]; v.rd = rd[1:0]; v.rs = rs[1:0]; v.rt = rt[1:0];
    v.imm = imm[7:0]; v.res = res[7:0]; v.z = z[0]; v.c = c[0];
    v.lat = (op == 15) ? 9 : 2;
    return v;
  endfunction

  // Reference behaviour from plain integer arithmetic on 0..255 operands.
  function automatic void model(input int op, input int a, input int b, input int imm,
                                output int res, output int c);
    int t;
    c = 0;
    case (op)
      0:  begin t = a + b; res = t % 256; c = (t > 255) ? 1 : 0; end
      1:  begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2:  res = a & b;
      3:  res = a | b;
      4:  res = a ^ b;
      5:  begin res = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
      6:  begin res = a / 2; c = a % 2; end
      7:  res = a;
      14: res = imm;
      15: begin t = a * b; res = t % 256; c = (t > 255) ? 1 : 0; end
      default: res = 0;
    endcase
  endfunction

  task automatic do_cmd(input int op, input int rd, input int rs, input int rt, input int imm,
                        input int exp_res, input int exp_z, input int exp_c, input int exp_lat,
                        input string tag);
    int n, off, ready_bad;
    @(negedge clk);
    cmd_op = op[3:0]; cmd_rd = rd[1:0]; cmd_rs = rs[1:0]; cmd_rt = rt[1:0];
    cmd_imm = imm[7:0]; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    off = 1;
    ready_bad = 0;
    while (!done && off < 30) begin
      if (busy && cmd_ready) ready_bad = 1;
      @(posedge clk); #1; off++;
    end
    chk({tag, "_latency"}, off, exp_lat);
    chk({tag, "_ready_low_busy"}, ready_bad, 0);
    chk({tag, "_result"}, rsp_result, exp_res);
    chk({tag, "_zero"}, rsp_zero, exp_z);
    chk({tag, "_carry"}, rsp_carry, exp_c);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_ready_after"}, cmd_ready, 1);
  endtask

  initial begin
    int res, c, op, rd, rs, rt, imm;
    int accepts, dones, bad, cyc, idx;
    logic acc_now;
    logic [3:0] s_op[3];
    logic [1:0] s_rd[3], s_rs[3], s_rt[3];
    int s_exp[3];

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs = '0;
    cmd_rt = '0; cmd_imm = '0;
    for (int i = 0; i < 4; i++) mregs[i] = 0;

    vecs.push_back(mk(14, 0, 0, 0, 2,   2,   0, 0));
    vecs.push_back(mk(14, 1, 0, 0, 1,   1,   0, 0));
    vecs.push_back(mk(0,  2, 0, 1, 0,   3,   0, 0));
    vecs.push_back(mk(14, 0, 0, 0, 255, 255, 0, 0));
    vecs.push_back(mk(14, 1, 0, 0, 1,   1,   0, 0));
    vecs.push_back(mk(0,  2, 0, 1, 0,   0,   1, 1));
    vecs.push_back(mk(14, 3, 0, 0, 0,   0,   1, 0));
    vecs.push_back(mk(1,  2, 3, 1, 0,   255, 0, 1));
    vecs.push_back(mk(14, 0, 0, 0, 15,  15,  0, 0));
    vecs.push_back(mk(14, 1, 0, 0, 17,  17,  0, 0));
    vecs.push_back(mk(15, 2, 0, 1, 0,   255, 0, 0));
    vecs.push_back(mk(14, 0, 0, 0, 16,  16,  0, 0));
    vecs.push_back(mk(14, 1, 0, 0, 16,  16,  0, 0));
    vecs.push_back(mk(15, 3, 0, 1, 0,   0,   1, 1));
    vecs.push_back(mk(14, 0, 0, 0, 0,   0,   1, 0));
    vecs.push_back(mk(14, 1, 0, 0, 200, 200, 0, 0));
    vecs.push_back(mk(15, 2, 0, 1, 0,   0,   1, 0));
    vecs.push_back(mk(14, 1, 0, 0, 5,   5,   0, 0));
    vecs.push_back(mk(0,  1, 1, 1, 0,   10,  0, 0));
    vecs.push_back(mk(0,  2, 1, 0, 0,   10,  0, 0));
    vecs.push_back(mk(5,  3, 1, 0, 0,   20,  0, 0));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_zero", rsp_zero, 0);
    chk("rst_carry", rsp_carry, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_rst", cmd_ready, 1);

    foreach (vecs[i]) begin
      do_cmd(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].imm,
             vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].lat, $sformatf("vec%0d", i));
      mregs[vecs[i].rd] = vecs[i].res;
    end

    // Stream of three commands with cmd_valid held high throughout
    s_op[0] = 4'hE; s_rd[0] = 2'd3; s_rs[0] = 2'd0; s_rt[0] = 2'd0; s_exp[0] = 7;
    s_op[1] = 4'h0; s_rd[1] = 2'd2; s_rs[1] = 2'd3; s_rt[1] = 2'd3; s_exp[1] = 14;
    s_op[2] = 4'hF; s_rd[2] = 2'd1; s_rs[2] = 2'd3; s_rt[2] = 2'd2; s_exp[2] = 98;
    accepts = 0; dones = 0; bad = 0; cyc = 0; idx = 0;
    while (dones < 3 && cyc < 80) begin
      @(negedge clk);
      if (idx < 3) begin
        cmd_valid = 1'b1; cmd_op = s_op[idx]; cmd_rd = s_rd[idx];
        cmd_rs = s_rs[idx]; cmd_rt = s_rt[idx]; cmd_imm = 8'd7;
      end else cmd_valid = 1'b1;
      if (busy && cmd_ready) bad++;
      acc_now = cmd_valid && cmd_ready;
      if (acc_now) accepts++;
      @(posedge clk); #1;
      if (acc_now && idx < 3) idx++;
      if (done) begin
        if (dones < 3) chk($sformatf("stream_res%0d", dones), rsp_result, s_exp[dones]);
        dones++;
      end
      if (dones == 3) cmd_valid = 1'b0;
      cyc++;
    end
    cmd_valid = 1'b0;
    chk("stream_accepts", accepts, 3);
    chk("stream_dones", dones, 3);
    chk("stream_ready_busy", bad, 0);
    mregs[3] = 7; mregs[2] = 14; mregs[1] = 98;

    // Reset during the 4th MUL cycle: no completion, everything cleared
    @(negedge clk);
    cmd_op = 4'hF; cmd_rd = 2'd0; cmd_rs = 2'd1; cmd_rt = 2'd2; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1 chk("midrst_ready", cmd_ready, 0);
    @(posedge clk); #1;
    chk("midrst_done", done, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_ready_after", cmd_ready, 1);
    chk("midrst_result", rsp_result, 0);
    chk("midrst_zero", rsp_zero, 0);
    chk("midrst_carry", rsp_carry, 0);
    bad = 0;
    repeat (12) begin @(posedge clk); #1; if (done) bad++; end
    chk("midrst_no_done", bad, 0);
    for (int i = 0; i < 4; i++) mregs[i] = 0;
    do_cmd(0, 3, 0, 1, 0, 0, 1, 0, 2, "midrst_readback");

    // Random commands against the model
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 15);
      if (k % 3 == 0) op = 14;
      rd = $urandom_range(0, 3); rs = $urandom_range(0, 3); rt = $urandom_range(0, 3);
      imm = $urandom_range(0, 255);
      model(op, mregs[rs], mregs[rt], imm, res, c);
      do_cmd(op, rd, rs, rt, imm, res, (res == 0) ? 1 : 0, c, (op == 15) ? 9 : 2,
             $sformatf("rnd%0d_op%0d", k, op));
      mregs[rd] = res;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
